// File: rtl/sd_arb_pkg.sv
// ---------------------------------------------------------------------------
// sd_arb_pkg
// Shared definitions for the SD sector read arbiter family:
//   state_e       arbiter FSM states
//   SD_ST_IDLE    sector reader "idle / ready for a command" state code
//   SECTOR_BYTES  bytes streamed per sector read
// ---------------------------------------------------------------------------
package sd_arb_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_ISSUE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [4:0] SD_ST_IDLE   = 5'd10;
  localparam int         SECTOR_BYTES = 512;

endpackage

// File: rtl/sd_sector_read_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req_i starting at ptr_i and
// wrapping modulo NREQ; the first set bit found is the winner.
// Ports:
//   req_i     [NREQ]   pending request vector
//   ptr_i     [PTR_W]  index with highest priority this round (< NREQ)
//   any_o              at least one request pending
//   winner_o  [PTR_W]  index of the winning request (0 when any_o=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ  = 2,
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             any_o,
  output logic [PTR_W-1:0] winner_o
);

  int               idx;
  logic [PTR_W-1:0] sel;

  // Walk from the farthest slot back toward ptr_i so that the slot closest
  // to the pointer is the last (and therefore winning) assignment.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    idx      = 0;
    sel      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (req_i[sel]) begin
        any_o    = 1'b1;
        winner_o = sel;
      end
    end
  end

endmodule

// File: rtl/sd_sector_read_arbiter.sv
// ---------------------------------------------------------------------------
// sd_sector_read_arbiter
// Shares one SD SPI sector reader between NREQ requesters with round-robin
// arbitration. The granted requester's sector number is handed to the reader
// with a one-cycle start pulse, the 512-byte readout is steered back to it
// (registered, one cycle latency), and a done (or error) pulse ends the grant.
//
// Optional feature macro: SD_ARB_TIMEOUT_EN
//   defined   -> a read not finished within TIMEOUT_CYCLES busy cycles is
//                aborted with req_err and the arbiter re-waits for card IDLE
//   undefined -> no watchdog, req_err is constant 0
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[NREQ]         level requests, held until done/err
//   req_sector        32-bit sector per requester, requester i at [32*i+:32]
//   gnt[NREQ]         one-hot, high while requester owns the reader
//   req_done/req_err  one-cycle completion / abort pulses per requester
//   req_rvalid        byte strobe steered to the granted requester only
//   req_raddr/rdata   shared registered byte address / data (0 when idle)
//   rd_start          one-cycle start pulse to the reader
//   rd_sector_no      sector number presented to the reader
//   rd_done, rd_rvalid, rd_raddr, rd_rdata, rd_cardstate   reader outputs
//   busy              high in S_ISSUE, S_BUSY and S_DONE
// ---------------------------------------------------------------------------
module sd_sector_read_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NREQ           = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req,
  input  logic [32*NREQ-1:0]              req_sector,
  output logic [NREQ-1:0]                 gnt,
  output logic [NREQ-1:0]                 req_done,
  output logic [NREQ-1:0]                 req_err,
  output logic [NREQ-1:0]                 req_rvalid,
  output logic [$clog2(SECTOR_BYTES)-1:0] req_raddr,
  output logic [7:0]                      req_rdata,
  output logic                            rd_start,
  output logic [31:0]                     rd_sector_no,
  input  logic                            rd_done,
  input  logic                            rd_rvalid,
  input  logic [$clog2(SECTOR_BYTES)-1:0] rd_raddr,
  input  logic [7:0]                      rd_rdata,
  input  logic [7:0]                      rd_cardstate,
  output logic                            busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW    = $clog2(SECTOR_BYTES);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] win_q, win_d, rr_q, rr_d, pick_win;
  logic             pick_any, card_idle;
  logic [31:0]      sector_q, sector_d, pick_sector;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d, rv_q, rv_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             start_q, start_d;
`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0]      tmo_q, tmo_d;
`endif

  // Card type bits and, in the default build, the timeout value are not
  // needed by the datapath.
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, rd_cardstate[7:5]};

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + PTR_W'(1);
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req),
    .ptr_i    (rr_q),
    .any_o    (pick_any),
    .winner_o (pick_win)
  );

  assign card_idle = (rd_cardstate[4:0] == SD_ST_IDLE);

  always_comb begin
    pick_sector = req_sector[31:0];
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win == PTR_W'(i)) pick_sector = req_sector[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_d     = rr_q;
    sector_d = sector_q;
    gnt_d    = gnt_q;
    start_d  = 1'b0;
    done_d   = '0;
    err_d    = '0;
    rv_d     = '0;
    raddr_d  = '0;
    rdata_d  = '0;
`ifdef SD_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      S_INIT: begin
        if (card_idle) state_d = S_ARB;
      end
      S_ARB: begin
        // Card fell out of IDLE (e.g. reader re-initialising): no grants.
        if (!card_idle) begin
          state_d = S_INIT;
        end else if (pick_any) begin
          win_d    = pick_win;
          sector_d = pick_sector;
          gnt_d    = onehot(pick_win);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_BUSY;
`ifdef SD_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_BUSY: begin
        if (rd_rvalid) begin
          rv_d    = onehot(win_q);
          raddr_d = rd_raddr;
          rdata_d = rd_rdata;
        end
        if (rd_done) begin
          done_d  = onehot(win_q);
          gnt_d   = '0;
          state_d = S_DONE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
          // Abort: the reader is presumed wedged, so re-check card state
          // before granting anyone else.
          err_d   = onehot(win_q);
          gnt_d   = '0;
          rr_d    = next_ptr(win_q);
          state_d = S_INIT;
        end else begin
          tmo_d   = tmo_q + 24'd1;
        end
`endif
      end
      S_DONE: begin
        rr_d    = next_ptr(win_q);
        state_d = S_ARB;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      win_q    <= '0;
      rr_q     <= '0;
      sector_q <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      rv_q     <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      sector_q <= sector_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign req_done     = done_q;
  assign req_rvalid   = rv_q;
  assign req_raddr    = raddr_q;
  assign req_rdata    = rdata_q;
  assign rd_start     = start_q;
  assign rd_sector_no = sector_q;
  assign busy         = (state_q != S_INIT) && (state_q != S_ARB);
`ifdef SD_ARB_TIMEOUT_EN
  assign req_err      = err_q;
`else
  assign req_err      = '0;
  logic unused_err;
  assign unused_err   = ^err_q;
`endif

endmodule

// File: doc/sd_sector_read_arbiter.md
Name: sd_sector_read_arbiter

Overview:
- Shares one SD SPI sector reader between NREQ independent requesters.
- Round-robin arbitration over pending requests.
- For the granted requester: issues the reader's single-cycle start with that requester's sector number, steers the 512-byte readout stream to it, and returns a completion or error pulse.
- Sits between the user read clients (file/FAT walker, loader, debug port) and the sector reader.

Parameters:
- NREQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 24'd4000000, clocks allowed from start to reader done before error (used only with the timeout feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester read request, level, held until its done/err
- req_sector  in  32*NREQ  sector number, requester i at [32*i+:32]
- gnt  out  NREQ  one-hot, high while requester i owns the reader
- req_done  out  NREQ  1-cycle pulse, sector delivered to requester i
- req_err  out  NREQ  1-cycle pulse, read of requester i aborted
- req_rvalid  out  NREQ  rvalid steered to granted requester only
- req_raddr  out  9  byte address 0..511, shared
- req_rdata  out  8  byte data, shared
- rd_start  out  1  reader start pulse
- rd_sector_no  out  32  reader sector number
- rd_done  in  1  reader completion pulse
- rd_rvalid  in  1  reader byte strobe
- rd_raddr  in  9  reader byte address
- rd_rdata  in  8  reader byte
- rd_cardstate  in  8  reader status {cardtype[1:0],1'b0,state[4:0]}
- busy  out  1  high in any state except S_INIT/S_ARB

Behaviour:
- Reset (rst high at posedge):
  - state=S_INIT, rr_ptr=0.
  - All outputs 0; rd_sector_no=0.
  - Abandons any transfer in flight. The reader's own reset is tied to the same source by the integrator.
- S_INIT: wait until rd_cardstate[4:0]==SD_ST_IDLE (5'd10), then go to S_ARB. No grants are issued before this.
- S_ARB:
  - If req!=0, pick the first set bit starting at rr_ptr, wrapping modulo NREQ.
  - Latch the winner index and its req_sector into rd_sector_no.
  - Assert gnt[winner] from the next cycle; go to S_ISSUE.
- S_ISSUE:
  - rd_start=1 for exactly one cycle; go to S_BUSY.
  - rd_sector_no stays stable from S_ISSUE until leaving S_BUSY.
- S_BUSY:
  - req_rvalid[winner]=rd_rvalid, registered with 1-cycle latency; req_raddr/req_rdata are registered copies.
  - All other req_rvalid bits stay 0. req_raddr/req_rdata are 0 when rd_rvalid=0.
  - On rd_done go to S_DONE.
- S_DONE:
  - req_done[winner]=1 for one cycle; gnt cleared the same cycle.
  - rr_ptr=(winner+1) mod NREQ; go to S_ARB.
  - Back-to-back: the next grant is chosen in S_ARB on the following cycle. Minimum gap between successive rd_start pulses is 3 cycles plus the read time.
- Requester drops req during its grant: the transfer still completes and req_done still pulses. A new request is not accepted until the requester sees done/err.
- rd_cardstate leaves IDLE while in S_ARB: return to S_INIT, no grant.
- Simultaneous req bits: only one winner per arbitration. The others stay pending. Fairness: any pending requester is served within NREQ grants.
- rd_done in S_ISSUE or S_ARB (spurious) is ignored.
- req_sector changes after the S_ARB latch have no effect on the transfer in flight.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- When defined:
  - A 24-bit counter clears on entry to S_BUSY and increments every S_BUSY cycle.
  - On reaching TIMEOUT_CYCLES: pulse req_err[winner] one cycle instead of req_done, clear gnt, advance rr_ptr, go to S_INIT.
  - A late rd_done is then ignored.
- When undefined: no counter, req_err is tied to 0, and S_BUSY waits for rd_done indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - state enum {S_INIT, S_ARB, S_ISSUE, S_BUSY, S_DONE}
  - SD_ST_IDLE=5'd10
  - SECTOR_BYTES=512
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[NREQ], rr_ptr. Outputs: any, winner index.
  - Reused by future multi-client SD blocks.

Test Plan:
- Init gating: rd_cardstate=8'h04 (ACMD41) for 100 cycles with req=2'b01 → no gnt, no rd_start. Then set 8'hCA → gnt=01 within 2 cycles, rd_start one cycle later, rd_sector_no=req_sector[31:0].
- Single read: req0 with sector 32'h0000_0800; model emits 512 rd_rvalid bytes addr 511..0 then rd_done → req_rvalid[0] 512 pulses, req_rvalid[1] never high, data/addr match with 1-cycle delay, one req_done[0] pulse, gnt=0 after.
- Round-robin: req=2'b11 held continuously with sectors 5 and 9 → grant order 0,1,0,1; rd_sector_no alternates 5,9; no requester served twice in a row.
- Mid-transfer sector change: after the grant, change req_sector[0] to 32'hFFFF → rd_sector_no stays at the original value until req_done.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=1000): rd_done withheld → req_err[1] pulse exactly 1000 cycles after S_BUSY entry, no req_done; a later rd_done has no effect.
- Reset mid-read: assert rst at byte 100 → next cycle all outputs 0, gnt=0, state S_INIT; after release the arbiter waits for IDLE before granting again.
